mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM: a read/write CPU port and a read-only
// infer/debug port share the memory with a fixed 3-cycle access and bounded CPU streaks.
module mem_port_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              fast_clk,
   input  logic              rst_n,
   input  logic              top_en,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              inf_req,
   input  logic [ADDR_W-1:0] inf_addr,
   output logic              inf_gnt,
   output logic              inf_rvalid,
   output logic [DATA_W-1:0] inf_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      INF_ACC = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic                owner_inf_reg, owner_inf_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic                we_reg, we_next;
   logic [STREAK_W-1:0] streak_reg, streak_next;

   always_ff @(posedge fast_clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         owner_inf_reg <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         we_reg        <= 1'b0;
         streak_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         owner_inf_reg <= owner_inf_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         we_reg        <= we_next;
         streak_reg    <= streak_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      owner_inf_next = owner_inf_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      we_next        = we_reg;
      streak_next    = streak_reg;

      case (state_reg)
         IDLE: begin
            // The streak only measures CPU wins while the infer port is actually waiting.
            if (!inf_req) begin
               streak_next = '0;
            end
            if (top_en && (cpu_req || inf_req)) begin
               if (inf_req && (!cpu_req || streak_reg >= STREAK_MAX)) begin
                  state_next     = INF_ACC;
                  owner_inf_next = 1'b1;
                  addr_next      = inf_addr;
                  wdata_next     = '0;
                  we_next        = 1'b0;
                  streak_next    = '0;
               end else begin
                  state_next     = CPU_ACC;
                  owner_inf_next = 1'b0;
                  addr_next      = cpu_addr;
                  wdata_next     = cpu_wdata;
                  we_next        = cpu_we;
                  if (inf_req && streak_reg < STREAK_MAX) begin
                     streak_next = streak_reg + 1'b1;
                  end
               end
            end
         end
         CPU_ACC: state_next = RESP;
         INF_ACC: state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign cpu_gnt    = (state_reg == CPU_ACC);
   assign inf_gnt    = (state_reg == INF_ACC);
   assign mem_en     = cpu_gnt || inf_gnt;
   assign mem_we     = cpu_gnt && we_reg;
   assign mem_addr   = addr_reg;
   assign mem_wdata  = wdata_reg;
   assign cpu_rvalid = (state_reg == RESP) && !owner_inf_reg;
   assign inf_rvalid = (state_reg == RESP) && owner_inf_reg;
   assign busy       = (state_reg != IDLE);

   logic [1:0]        port_rvalid;
   logic [DATA_W-1:0] port_rdata [2];

   assign port_rvalid = {inf_rvalid, cpu_rvalid};

   // Read data is passed straight through in RESP so it lines up with rvalid, and is
   // captured at the same time so the port keeps showing it until its next read.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] rdata_reg;
         logic              capture;

         assign capture = port_rvalid[gi] && !we_reg;

         always_ff @(posedge fast_clk) begin
            if (!rst_n) begin
               rdata_reg <= '0;
            end else if (capture) begin
               rdata_reg <= mem_rdata;
            end
         end

         assign port_rdata[gi] = capture ? mem_rdata : rdata_reg;
      end
   endgenerate

   assign cpu_rdata = port_rdata[0];
   assign inf_rdata = port_rdata[1];

endmodule
